channel_snapshot_tx: RTL and testbench

Multi-channel event counter with a framed serial transmitter, generalising the single 64-bit counter/transmitter pair.
- Counts one-cycle event pulses on `CHANNELS` independent inputs.
- On a `snapshot` pulse, latches and clears all counters, then shifts a header, every channel value and an optional checksum out on the three-wire `transmission`/`clock`/`data` link.
- Sits between the pulse generators and the board pins.

---
 rtl/channel_snapshot_tx_pkg.sv | 21 ++
 rtl/channel_snapshot_tx_if.sv | 11 +
 rtl/channel_snapshot_tx_event_counter.sv | 23 ++
 rtl/channel_snapshot_tx.sv | 171 +++++++++++++++++
 tb/tb_channel_snapshot_tx.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/channel_snapshot_tx_pkg.sv
// Shared types and helpers for the multi-channel snapshot transmitter.
// frame_len() accounts for the optional checksum byte (CHANNEL_SNAPSHOT_TX_CHECKSUM_EN).
package snapshot_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } tx_state_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Frame length in serial bits: header byte, all channel fields, optional checksum byte.
  function automatic int unsigned frame_len(input int unsigned channels,
                                            input int unsigned width,
                                            input bit          chk_en);
    return 8 + channels * width + (chk_en ? 8 : 0);
  endfunction

endpackage

// File: rtl/channel_snapshot_tx_if.sv
// Three-wire serial link driven by channel_snapshot_tx toward the board pins.
interface channel_snapshot_tx_if;

  logic transmission;
  logic clock;
  logic data;

  modport master (output transmission, output clock, output data);
  modport slave  (input  transmission, input  clock, input  data);

endinterface

// File: rtl/channel_snapshot_tx_event_counter.sv
// Saturating per-channel event counter; load restarts the interval at 0 or 1.
module event_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  output logic [WIDTH-1:0] count
);

  // An event coincident with load belongs to the new interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= {{(WIDTH-1){1'b0}}, inc};
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/channel_snapshot_tx.sv
// Multi-channel event counter with framed serial snapshot transmitter.
// Optional trailing XOR checksum byte: define CHANNEL_SNAPSHOT_TX_CHECKSUM_EN.
//
// state     | meaning
// S_IDLE    | link quiet, waiting for snapshot
// S_HEADER  | shifting the 8-bit frame start byte
// S_PAYLOAD | shifting all channel values, channel 0 first
// S_CHECK   | shifting the payload XOR byte (checksum build only)
module channel_snapshot_tx
  import snapshot_tx_pkg::*;
#(
  parameter int         CHANNELS = 4,
  parameter int         WIDTH    = 32,
  parameter int         CLK_DIV  = 8,
  parameter logic [7:0] HEADER   = DEFAULT_HEADER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   inc,
  input  logic                  snapshot,
  output logic                  busy,
  output logic                  overrun,
  channel_snapshot_tx_if.master link
);

  localparam int PAY_BITS = CHANNELS * WIDTH;
  localparam int BIT_W    = $clog2(PAY_BITS);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BIT_W-1:0] PAY_LAST  = BIT_W'(PAY_BITS - 1);
  localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  tx_state_e             state, state_nxt;
  logic [PAY_BITS-1:0]   shadow;
  logic [PAY_BITS-1:0]   snap_val;
  logic [7:0]            hdr_sr;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_reload;
  logic [DIV_W-1:0]      div_cnt;
  logic                  sclk;
  logic                  accept;
  logic                  bit_end;
  logic                  last_bit;
  logic                  tx_bit;
  logic                  active;
  logic [WIDTH-1:0]      count [CHANNELS];
`ifdef CHANNEL_SNAPSHOT_TX_CHECKSUM_EN
  logic [7:0]            chk;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    event_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[i]),
      .load  (accept),
      .count (count[i])
    );
  end

  // Channel 0 lands in the most significant field so it is sent first.
  always_comb begin
    snap_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      snap_val[(CHANNELS-1-i)*WIDTH +: WIDTH] = count[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    tx_bit     = 1'b0;
    bit_reload = '0;
    bit_end    = (state != S_IDLE) && (div_cnt == '0) && sclk;
    last_bit   = (bit_cnt == '0);
    case (state)
      S_IDLE: begin
        accept = snapshot;
        if (snapshot) state_nxt = S_HEADER;
      end
      S_HEADER: begin
        tx_bit     = hdr_sr[7];
        bit_reload = PAY_LAST;
        if (bit_end && last_bit) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        tx_bit     = shadow[PAY_BITS-1];
        bit_reload = BYTE_LAST;
`ifdef CHANNEL_SNAPSHOT_TX_CHECKSUM_EN
        if (bit_end && last_bit) state_nxt = S_CHECK;
`else
        if (bit_end && last_bit) state_nxt = S_IDLE;
`endif
      end
`ifdef CHANNEL_SNAPSHOT_TX_CHECKSUM_EN
      S_CHECK: begin
        tx_bit = chk[7];
        if (bit_end && last_bit) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divider runs clock low for CLK_DIV cycles then high for CLK_DIV; bits advance on the high->low turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      hdr_sr  <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sclk    <= 1'b0;
      overrun <= 1'b0;
`ifdef CHANNEL_SNAPSHOT_TX_CHECKSUM_EN
      chk     <= '0;
`endif
    end else begin
      if (snapshot && (state != S_IDLE)) overrun <= 1'b1;
      if (accept) begin
        shadow  <= snap_val;
        hdr_sr  <= HEADER;
        bit_cnt <= BYTE_LAST;
        div_cnt <= DIV_LAST;
        sclk    <= 1'b0;
`ifdef CHANNEL_SNAPSHOT_TX_CHECKSUM_EN
        chk     <= '0;
`endif
      end else if (state != S_IDLE) begin
        if (div_cnt != '0) begin
          div_cnt <= div_cnt - 1'b1;
        end else begin
          div_cnt <= DIV_LAST;
          sclk    <= ~sclk;
          if (sclk) begin
            bit_cnt <= last_bit ? bit_reload : bit_cnt - 1'b1;
            case (state)
              S_HEADER:  hdr_sr <= {hdr_sr[6:0], 1'b0};
              S_PAYLOAD: begin
                shadow <= {shadow[PAY_BITS-2:0], 1'b0};
`ifdef CHANNEL_SNAPSHOT_TX_CHECKSUM_EN
                // Byte-aligned payload: the low three bits of the down-count give the checksum bit.
                chk[bit_cnt[2:0]] <= chk[bit_cnt[2:0]] ^ shadow[PAY_BITS-1];
`endif
              end
`ifdef CHANNEL_SNAPSHOT_TX_CHECKSUM_EN
              S_CHECK:   chk <= {chk[6:0], 1'b0};
`endif
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign active            = (state != S_IDLE);
  assign busy              = active;
  assign link.transmission = active;
  assign link.clock        = sclk;
  assign link.data         = tx_bit;

endmodule

// File: tb/tb_channel_snapshot_tx.sv
// Scoreboard bench for channel_snapshot_tx (CHANNELS=2, WIDTH=8, CLK_DIV=2).
// Follows CHANNEL_SNAPSHOT_TX_CHECKSUM_EN for the expected frame shape.
module tb_channel_snapshot_tx;
  import snapshot_tx_pkg::*;

  localparam int CH  = 2;
  localparam int W   = 8;
  localparam int DIV = 2;
`ifdef CHANNEL_SNAPSHOT_TX_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int FRAME_CYC = 2 * DIV * int'(frame_len(CH, W, CHK));
  localparam int NB        = int'(frame_len(CH, W, CHK)) / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] inc = 2'b00;
  logic       snapshot = 1'b0;
  logic       busy;
  logic       overrun;

  channel_snapshot_tx_if link();

  channel_snapshot_tx #(.CHANNELS(CH), .WIDTH(W), .CLK_DIV(DIV), .HEADER(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .inc      (inc),
    .snapshot (snapshot),
    .busy     (busy),
    .overrun  (overrun),
    .link     (link)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  // All stimulus tasks start and end on a falling clock edge.
  task automatic pulse(input logic [1:0] mask, input int n);
    inc = mask;
    repeat (n) @(negedge clk);
    inc = 2'b00;
  endtask

  task automatic do_snapshot();
    snapshot = 1'b1;
    @(negedge clk);
    snapshot = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] c0, input logic [7:0] c1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(c0);
    exp_q.push_back(c1);
    if (CHK) exp_q.push_back(c0 ^ c1);
  endtask

  // Decodes one frame from the link: bytes go to rx_q, returns cycles high and end-of-frame pin levels.
  task automatic receive(output int cyc, output logic endc, output logic endd);
    int k;
    int nb;
    logic prev;
    logic [7:0] sr;
    k = 0; nb = 0; prev = 1'b0; sr = 8'h00; cyc = 0;
    while (link.transmission !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    while (link.transmission === 1'b1 && cyc < 2000) begin
      cyc++;
      if (link.clock === 1'b1 && prev === 1'b0) begin
        sr = {sr[6:0], link.data};
        nb++;
        if (nb == 8) begin
          rx_q.push_back(sr);
          nb = 0;
        end
      end
      prev = link.clock;
      @(negedge clk);
    end
    endc = link.clock;
    endd = link.data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (link.transmission !== 1'b0) begin errors++; $display("FAIL reset_tx: got %b expected 0", link.transmission); end
    checks++; if (link.clock !== 1'b0) begin errors++; $display("FAIL reset_clock: got %b expected 0", link.clock); end
    checks++; if (link.data !== 1'b0) begin errors++; $display("FAIL reset_data: got %b expected 0", link.data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc; logic ec, ed; logic [7:0] e, a;
    rx_q.delete();
    pulse(2'b01, 3);
    pulse(2'b10, 5);
    push_frame(8'h03, 8'h05);
    do_snapshot();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    receive(cyc, ec, ed);
    checks++; if (cyc !== FRAME_CYC) begin errors++; $display("FAIL basic_len: got %0d cycles expected %0d", cyc, FRAME_CYC); end
    checks++; if (ec !== 1'b0) begin errors++; $display("FAIL basic_end_clock: got %b expected 0", ec); end
    checks++; if (ed !== 1'b0) begin errors++; $display("FAIL basic_end_data: got %b expected 0", ed); end
    checks++; if (rx_q.size() != NB) begin errors++; $display("FAIL basic_nbytes: got %0d expected %0d", rx_q.size(), NB); end
    for (int i = 0; i < NB; i++) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_saturation();
    int cyc; logic ec, ed; logic [7:0] e, a;
    rx_q.delete();
    pulse(2'b01, 300);
    push_frame((300 > 255) ? 8'hFF : 8'(300), 8'h00);
    do_snapshot();
    receive(cyc, ec, ed);
    checks++; if (rx_q.size() != NB) begin errors++; $display("FAIL sat_nbytes: got %0d expected %0d", rx_q.size(), NB); end
    for (int i = 0; i < NB; i++) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL sat_byte%0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_simultaneous();
    int cyc; logic ec, ed; logic [7:0] e, a;
    rx_q.delete();
    inc = 2'b01;
    push_frame(8'h00, 8'h00);
    do_snapshot();
    inc = 2'b00;
    receive(cyc, ec, ed);
    push_frame(8'h01, 8'h00);
    do_snapshot();
    receive(cyc, ec, ed);
    checks++; if (rx_q.size() != 2 * NB) begin errors++; $display("FAIL simul_nbytes: got %0d expected %0d", rx_q.size(), 2 * NB); end
    for (int i = 0; i < 2 * NB; i++) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL simul_byte%0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic ec, ed; logic [7:0] e, a;
    rx_q.delete();
    pulse(2'b10, 2);
    push_frame(8'h00, 8'h02);
    do_snapshot();
    receive(cyc, ec, ed);
    // Now in the cycle busy has fallen; a snapshot here must be accepted.
    push_frame(8'h00, 8'h00);
    do_snapshot();
    checks++; if (link.transmission !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b expected 1", link.transmission); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    receive(cyc, ec, ed);
    checks++; if (cyc !== FRAME_CYC) begin errors++; $display("FAIL b2b_len: got %0d cycles expected %0d", cyc, FRAME_CYC); end
    checks++; if (rx_q.size() != 2 * NB) begin errors++; $display("FAIL b2b_nbytes: got %0d expected %0d", rx_q.size(), 2 * NB); end
    for (int i = 0; i < 2 * NB; i++) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_overrun();
    int cyc; logic ec, ed; logic [7:0] e, a;
    rx_q.delete();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial: got %b expected 0", overrun); end
    push_frame(8'h00, 8'h00);
    do_snapshot();
    fork
      receive(cyc, ec, ed);
      begin
        repeat (20) @(negedge clk);
        do_snapshot();
        pulse(2'b10, 4);
      end
    join
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    checks++; if (cyc !== FRAME_CYC) begin errors++; $display("FAIL ovr_len: got %0d cycles expected %0d", cyc, FRAME_CYC); end
    push_frame(8'h00, 8'h04);
    do_snapshot();
    receive(cyc, ec, ed);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    checks++; if (rx_q.size() != 2 * NB) begin errors++; $display("FAIL ovr_nbytes: got %0d expected %0d", rx_q.size(), 2 * NB); end
    for (int i = 0; i < 2 * NB; i++) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL ovr_byte%0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc; logic ec, ed; logic [7:0] e, a;
    rx_q.delete();
    do_snapshot();
    pulse(2'b01, 5);
    repeat (40) @(negedge clk);
    checks++; if (link.transmission !== 1'b1) begin errors++; $display("FAIL rmid_inframe: got %b expected 1", link.transmission); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (link.transmission !== 1'b0) begin errors++; $display("FAIL rmid_tx: got %b expected 0", link.transmission); end
    checks++; if (link.clock !== 1'b0) begin errors++; $display("FAIL rmid_clock: got %b expected 0", link.clock); end
    checks++; if (link.data !== 1'b0) begin errors++; $display("FAIL rmid_data: got %b expected 0", link.data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %b expected 0", overrun); end
    @(negedge clk);
    push_frame(8'h00, 8'h00);
    do_snapshot();
    receive(cyc, ec, ed);
    checks++; if (rx_q.size() != NB) begin errors++; $display("FAIL rmid_nbytes: got %0d expected %0d", rx_q.size(), NB); end
    for (int i = 0; i < NB; i++) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL rmid_byte%0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (link.transmission !== 1'b0 || link.clock !== 1'b0 || link.data !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_simultaneous();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
